// File: rtl/clk_edge_monitor.sv
// Frequency monitor for a slow clock-like input: counts its rising edges over a fixed
// gate window in the clk domain and derives in-range, locked and loss-of-lock status.
module clk_edge_monitor #(
    parameter int unsigned GATE_CYCLES = 50000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned EXP_MIN     = 990,
    parameter int unsigned EXP_MAX     = 1010,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] edge_count,
    output logic             count_valid,
    output logic             in_range,
    output logic             locked,
    output logic             lost
);

    localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned LOCK_W = $clog2(LOCK_COUNT + 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_FULL = LOCK_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic s1, s2, s3;
    logic edge_det;

    logic [GATE_W-1:0] gate_cnt, gate_nxt;
    logic [CNT_W-1:0]  edge_cnt, edge_nxt;
    logic [LOCK_W-1:0] lock_cnt, lock_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              valid_nxt, range_nxt, locked_nxt, lost_nxt;

    logic [CNT_W-1:0]  closing_cnt;
    logic [LOCK_W-1:0] lock_inc;
    logic              window_ok;

    // s1/s2 resynchronise sig_in; s3 is the previous synchronised value for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det = s2 & ~s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            lock_cnt    <= '0;
            edge_count  <= '0;
            count_valid <= 1'b0;
            in_range    <= 1'b0;
            locked      <= 1'b0;
            lost        <= 1'b0;
        end else begin
            state       <= state_nxt;
            gate_cnt    <= gate_nxt;
            edge_cnt    <= edge_nxt;
            lock_cnt    <= lock_nxt;
            edge_count  <= count_nxt;
            count_valid <= valid_nxt;
            in_range    <= range_nxt;
            locked      <= locked_nxt;
            lost        <= lost_nxt;
        end
    end

    // closing_cnt already includes an edge seen in the current cycle, so an edge on the
    // last gate cycle lands in the window that is closing
    always_comb begin
        state_nxt   = state;
        gate_nxt    = gate_cnt;
        edge_nxt    = edge_cnt;
        lock_nxt    = lock_cnt;
        count_nxt   = edge_count;
        valid_nxt   = 1'b0;
        range_nxt   = in_range;
        locked_nxt  = locked;
        lost_nxt    = 1'b0;

        closing_cnt = (edge_det && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_W'(1) : edge_cnt;
        window_ok   = (32'(closing_cnt) >= EXP_MIN) && (32'(closing_cnt) <= EXP_MAX);
        lock_inc    = (lock_cnt == LOCK_FULL) ? lock_cnt : lock_cnt + LOCK_W'(1);

        if (!enable) begin
            state_nxt  = IDLE;
            gate_nxt   = '0;
            edge_nxt   = '0;
            lock_nxt   = '0;
            range_nxt  = 1'b0;
            locked_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = COUNT;
                    gate_nxt  = '0;
                    edge_nxt  = '0;
                end
                COUNT: begin
                    if (gate_cnt == GATE_LAST) begin
                        gate_nxt  = '0;
                        edge_nxt  = '0;
                        count_nxt = closing_cnt;
                        valid_nxt = 1'b1;
                        range_nxt = window_ok;
                        if (window_ok) begin
                            lock_nxt   = lock_inc;
                            locked_nxt = (lock_inc == LOCK_FULL);
                        end else begin
                            lock_nxt   = '0;
                            locked_nxt = 1'b0;
                            lost_nxt   = locked;
                        end
                    end else begin
                        gate_nxt = gate_cnt + GATE_W'(1);
                        edge_nxt = closing_cnt;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/clk_edge_monitor.md
Name: clk_edge_monitor

Overview:
- Checks a slow or externally derived clock-like signal (e.g. a divided PLL output or an RF-carrier divider tap) by sampling it in the system clock domain.
- Counts its rising edges over a fixed gate window and compares the count against an expected range.
- Reports lock and loss-of-lock to the transmitter control logic, so the carrier path is enabled only when the synthesized clock is present and on frequency.

Parameters:
- GATE_CYCLES, 50000, gate window length in clk cycles (1 ms at 50 MHz); must be >= 4.
- CNT_W, 16, width of the edge counter and count output.
- EXP_MIN, 990, minimum edge count per window for in-range (inclusive).
- EXP_MAX, 1010, maximum edge count per window for in-range (inclusive).
- LOCK_COUNT, 4, consecutive in-range windows required to assert locked; must be >= 1.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  monitor enable; low holds the block idle.
- sig_in  input  1  monitored signal, asynchronous to clk; frequency must be < clk/4.
- edge_count  output  CNT_W  edge count of the last completed window.
- count_valid  output  1  one-cycle pulse when edge_count updates.
- in_range  output  1  last completed window satisfied EXP_MIN <= count <= EXP_MAX.
- locked  output  1  lock indication.
- lost  output  1  one-cycle pulse on a locked 1->0 transition caused by an out-of-range window.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Clears sync flops, edge detector, gate counter, edge counter and lock counter.
  - Outputs: edge_count=0, count_valid=0, in_range=0, locked=0, lost=0.
  - The FSM goes to IDLE.
- Input conditioning: two-flop synchronizer, then a third flop for edge detection. edge = s2 & ~s3. A sig_in rising edge produces edge 3 clk cycles later.
- FSM states:
  - IDLE: counters held at 0. When enable=1, go to COUNT on the next cycle with gate counter = 0.
  - COUNT: gate counter increments every cycle. The edge counter increments on each edge and saturates at 2^CNT_W-1 (no wrap).
    - When gate counter = GATE_CYCLES-1, that cycle is the last of the window. An edge in that cycle belongs to the closing window.
    - Next cycle: edge_count <= final count, count_valid=1, in_range updated, gate counter and edge counter restart at 0. An edge in this cycle counts as 1 for the new window. Windows are back-to-back with no dead cycles, and the FSM stays in COUNT.
  - enable=0 in any state: next cycle go to IDLE. The partial window is discarded with no count_valid. locked, in_range and the lock counter are cleared, and lost is not pulsed. edge_count holds its last value.
- Lock counter (0..LOCK_COUNT, saturating), evaluated at each window close:
  - In-range window: the counter increments. locked asserts in the same cycle as count_valid for the window that brings the counter to LOCK_COUNT.
  - Out-of-range window: the counter clears to 0 and locked deasserts that same cycle. If locked was 1, lost pulses for 1 cycle, coincident with count_valid.
  - A saturated edge count is out of range whenever EXP_MAX < 2^CNT_W-1.
- Timing: in_range, locked and lost change only in count_valid cycles, except when enable falls.
- Windows: the first window after enable rises is a full GATE_CYCLES window.
- Reset mid-window: all state is lost immediately. After release, the block waits for enable as from IDLE.
- Outputs are registered, with no combinational paths from inputs.

Test Plan (GATE_CYCLES=100, EXP_MIN=9, EXP_MAX=11, LOCK_COUNT=3, CNT_W=8 unless noted):
- Reset then idle: rst_n low with sig_in toggling -> all outputs 0. After release with enable=0 for 500 cycles -> count_valid never pulses.
- Nominal lock: enable=1, sig_in period 10 clk -> count_valid every 100 cycles with edge_count=10 and in_range=1. locked rises exactly at the 3rd count_valid; lost stays 0.
- Loss of lock: after lock, change sig_in period to 20 clk -> the first window containing slow edges reports edge_count within 5..9. At the first out-of-range report, locked falls and lost pulses once, in the same cycle as count_valid. Restore period 10 -> locked re-asserts after 3 further in-range windows.
- Boundary edge and saturation: place an edge on the last window cycle -> it is counted in the closing window. With a separate edge on the first cycle of the next window -> that window starts at 1. CNT_W=4, GATE_CYCLES=200, sig_in period 8 -> edge_count=15 (saturated) and in_range=0.
- Enable drop mid-window: locked, drop enable at cycle 50 of a window -> next cycle locked=0, in_range=0, lost=0, no count_valid, edge_count holds 10. Re-enable -> first count_valid 100 cycles later.
- Async reset mid-window: assert rst_n low between clock edges while locked -> outputs clear without a clk edge. After release, behaviour matches the nominal lock scenario.
